instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the single-cycle-issue, non-pipelined MIPS core. Holds the program counter, fetches one 32-bit word from instruction memory over a request/ready handshake, and presents it with a valid flag to the opcode decoder and the datapath. Once the datapath commits the instruction, it computes the next PC from the decoder's jump/branch outputs and the ALU zero flag.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; must be word-aligned.
- TIMEOUT_CYCLES, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the word; bits [1:0] always 0.
- imem_ready  input  1  memory accepts the request and imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  latched instruction; bits [31:26] drive the decoder.
- instr_valid  output  1  instr is valid and awaiting commit.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- commit  input  1  datapath has finished the current instruction.
- jump  input  1  decoder jump.
- branch  input  2  decoder branch: 0 none, 1 BEQ, 2 BNE, 3 reserved (treated as none).
- zero  input  1  ALU zero flag.
- branch_imm  input  16  instruction immediate; sign-extended internally.
- jump_target  input  26  instruction index field.
- fetch_fault  output  1  sticky watchdog flag; only with FETCH_TIMEOUT_EN, otherwise tied to 0.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: entered on reset. Moves to FETCH on the next cycle.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held stable until imem_ready.
  - When imem_ready is sampled high: instr <= imem_rdata, move to HOLD.
- HOLD:
  - instr_valid = 1 and imem_req = 0.
  - When commit is sampled high: pc <= next_pc and move to FETCH. instr is retained; instr_valid drops.
- commit outside HOLD is ignored. jump, branch, zero, branch_imm and jump_target are sampled only on the commit cycle.
- next_pc, by priority:
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - BEQ with zero = 1, or BNE with zero = 0: pc_plus4 + (sext(branch_imm) << 2), 32-bit wrap.
  - Otherwise: pc_plus4.
- PC arithmetic wraps: pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
- Reset in any state, including mid-handshake, forces:
  - pc = RESET_PC, state IDLE.
  - instr = 0, instr_valid = 0, imem_req = 0, fetch_fault = 0.
  - An imem_ready arriving in the reset cycle is discarded.

## Timing
- Reset exit:
  - First cycle after reset deasserts: IDLE.
  - Next cycle: imem_req = 1.
- Zero-wait memory (imem_ready high in the first FETCH cycle): instr_valid rises one cycle after the request cycle.
- Each wait cycle adds one cycle of latency.
- Commit to next request: one cycle. The first FETCH cycle after a commit already drives the new pc.
- Minimum instruction period with zero-wait memory and immediate commit: 2 cycles (FETCH, HOLD).
- All outputs are registered or decoded from state; none depends combinationally on an input.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs during FETCH.
  - If imem_ready has not arrived after TIMEOUT_CYCLES FETCH cycles: instr <= 32'h0000_0000 (NOP), fetch_fault <= 1, move to HOLD.
  - fetch_fault stays set until reset.
- FETCH_TIMEOUT_EN undefined: FETCH waits indefinitely, no counter is built, fetch_fault = 0.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005, commit in the first HOLD cycle:
  - imem_addr = 0.
  - instr_valid rises in cycle 3 after reset release.
  - Next request at address 4.
- Memory with 3 wait cycles:
  - imem_addr stays stable throughout the wait.
  - instr_valid rises 1 cycle after imem_ready.
  - commit held low for 5 cycles keeps instr and instr_valid stable.
- BEQ at pc = 0x10, branch_imm = 16'hFFFC:
  - zero = 1: next pc = 0x04.
  - zero = 0: next pc = 0x14.
  - BNE with zero = 0 and branch_imm = 3: next pc = 0x20.
- jump = 1, jump_target = 26'h0000100 at pc = 0x4000_0000 → next pc = 0x4000_0400. With jump and a taken branch asserted together, the jump wins.
- Reset asserted during a FETCH wait, with imem_ready arriving in the same cycle: data discarded, pc = RESET_PC, instr_valid = 0.
- With FETCH_TIMEOUT_EN, imem_ready never asserted: after 16 FETCH cycles, instr = 0, instr_valid = 1, fetch_fault = 1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, imem handshake, next-PC select
// Optional fetch watchdog built when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_target,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        branch_taken;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_q, fault_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign branch_off  = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Branch code 3 is reserved and falls through like "no branch".
    always_comb begin
        branch_taken = ((branch == 2'd1) && zero) || ((branch == 2'd2) && !zero);
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        count_d = '0;
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Hand the datapath a NOP so the core keeps moving.
                    instr_d = 32'h0000_0000;
                    fault_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    count_d = count_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (commit) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
            count_q <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
            count_q <= count_d;
            fault_q <= fault_d;
`endif
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven scoreboard bench for instr_fetch_unit
// Define FETCH_TIMEOUT_EN for both files to exercise the watchdog build.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        jump;
    logic [1:0]  branch;
    logic        zero;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .jump       (jump),
        .branch     (branch),
        .zero       (zero),
        .branch_imm (branch_imm),
        .jump_target(jump_target),
        .fetch_fault(fetch_fault)
    );

    typedef struct {
        logic [31:0] rdata;
        int          wait_n;
        int          hold_n;
        logic        jump;
        logic [1:0]  branch;
        logic        zero;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] next_pc;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic pop_addr(output logic [31:0] a);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got no entry required one");
            a = 32'h0;
        end else begin
            a = exp_q.pop_front();
        end
    endtask

    task automatic scramble_ctl();
        jump        = 1'($urandom);
        branch      = 2'($urandom);
        zero        = 1'($urandom);
        branch_imm  = 16'($urandom);
        jump_target = 26'($urandom);
    endtask

    initial begin
        //          rdata          w  h  jmp   br     z     imm        tgt          next_pc
        vecs[0]  = '{32'h2008_0005, 0, 0, 1'b0, 2'd0, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0004};
        vecs[1]  = '{32'h1000_0002, 3, 5, 1'b0, 2'd1, 1'b1, 16'h0002, 26'h0000000, 32'h0000_0010};
        vecs[2]  = '{32'h1000_FFFC, 0, 1, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0000000, 32'h0000_0004};
        vecs[3]  = '{32'h0800_0004, 1, 0, 1'b1, 2'd0, 1'b0, 16'h0000, 26'h0000004, 32'h0000_0010};
        vecs[4]  = '{32'h1000_FFFC, 0, 0, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0000000, 32'h0000_0014};
        vecs[5]  = '{32'h1000_FFFE, 2, 0, 1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0000000, 32'h0000_0010};
        vecs[6]  = '{32'h1400_0003, 0, 0, 1'b0, 2'd2, 1'b0, 16'h0003, 26'h0000000, 32'h0000_0020};
        vecs[7]  = '{32'h1400_0003, 0, 2, 1'b0, 2'd2, 1'b1, 16'h0003, 26'h0000000, 32'h0000_0024};
        vecs[8]  = '{32'hABCD_0005, 0, 0, 1'b0, 2'd3, 1'b1, 16'h0005, 26'h0000000, 32'h0000_0028};
        vecs[9]  = '{32'h0800_0100, 1, 0, 1'b1, 2'd1, 1'b1, 16'h0010, 26'h0000100, 32'h0000_0400};
        vecs[10] = '{32'h1000_8000, 0, 0, 1'b0, 2'd1, 1'b1, 16'h8000, 26'h0000000, 32'hFFFE_0404};
        vecs[11] = '{32'h1000_7EFC, 0, 0, 1'b0, 2'd1, 1'b1, 16'h7EFC, 26'h0000000, 32'hFFFF_FFF8};
        vecs[12] = '{32'h0BFF_FFFF, 0, 0, 1'b1, 2'd0, 1'b0, 16'h0000, 26'h3FFFFFF, 32'hFFFF_FFFC};
        vecs[13] = '{32'h0000_0000, 1, 0, 1'b0, 2'd0, 1'b1, 16'h0000, 26'h0000000, 32'h0000_0000};
        vecs[14] = '{32'h1400_FFFF, 0, 0, 1'b0, 2'd2, 1'b0, 16'hFFFF, 26'h0000000, 32'h0000_0000};
        vecs[15] = '{32'h0BFF_FFFF, 0, 0, 1'b1, 2'd0, 1'b0, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFC};

        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        commit     = 1'b0;
        scramble_ctl();
        repeat (2) @(negedge clk);
        check("rst_req",   32'(imem_req),    32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr,            32'h0);
        check("rst_pc",    pc,               32'h0);
        check("rst_fault", 32'(fetch_fault), 32'h0);

        reset = 1'b0;
        exp_q.push_back(32'h0000_0000);
        check("idle_no_req", 32'(imem_req), 32'h0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            pop_addr(cur_pc);
            check($sformatf("v%0d_req", i),   32'(imem_req),    32'h1);
            check($sformatf("v%0d_addr", i),  imem_addr,        cur_pc);
            check($sformatf("v%0d_valid0", i), 32'(instr_valid), 32'h0);
            check($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'h0);
            for (int w = 0; w < vecs[i].wait_n; w++) begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
                commit     = 1'($urandom);
                scramble_ctl();
                @(negedge clk);
                check($sformatf("v%0d_wait_req", i),   32'(imem_req),    32'h1);
                check($sformatf("v%0d_wait_addr", i),  imem_addr,        cur_pc);
                check($sformatf("v%0d_wait_valid", i), 32'(instr_valid), 32'h0);
            end
            imem_ready = 1'b1;
            imem_rdata = vecs[i].rdata;
            commit     = 1'($urandom);
            @(negedge clk);
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            commit     = 1'b0;
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'h1);
            check($sformatf("v%0d_instr", i), instr,            vecs[i].rdata);
            check($sformatf("v%0d_noreq", i), 32'(imem_req),    32'h0);
            check($sformatf("v%0d_pc", i),    pc,               cur_pc);
            check($sformatf("v%0d_pc4", i),   pc_plus4,         cur_pc + 32'd4);
            for (int h = 0; h < vecs[i].hold_n; h++) begin
                scramble_ctl();
                @(negedge clk);
                check($sformatf("v%0d_hold_valid", i), 32'(instr_valid), 32'h1);
                check($sformatf("v%0d_hold_instr", i), instr,            vecs[i].rdata);
            end
            commit      = 1'b1;
            jump        = vecs[i].jump;
            branch      = vecs[i].branch;
            zero        = vecs[i].zero;
            branch_imm  = vecs[i].imm;
            jump_target = vecs[i].tgt;
            exp_q.push_back(vecs[i].next_pc);
            @(negedge clk);
            commit = 1'b0;
            scramble_ctl();
            check($sformatf("v%0d_kept_instr", i), instr, vecs[i].rdata);
        end

        // Reset in the middle of a wait, with imem_ready landing in the reset cycle.
        pop_addr(cur_pc);
        check("mid_addr", imem_addr, cur_pc);
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset      = 1'b0;
        imem_ready = 1'b0;
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_instr", instr,            32'h0);
        check("mid_rst_pc",    pc,               32'h0);
        check("mid_rst_req",   32'(imem_req),    32'h0);
        @(negedge clk);
        check("mid_refetch_req",  32'(imem_req), 32'h1);
        check("mid_refetch_addr", imem_addr,     32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ready = 1'b0;
        check("mid_instr", instr, 32'h1234_5678);
        commit = 1'b1;
        jump   = 1'b0;
        branch = 2'd0;
        @(negedge clk);
        commit = 1'b0;
        check("stall_addr", imem_addr, 32'h0000_0004);

        // Memory never answers: 16 FETCH cycles, then watchdog or indefinite wait.
        repeat (15) @(negedge clk);
        check("stall_valid16", 32'(instr_valid), 32'h0);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        check("to_valid", 32'(instr_valid), 32'h1);
        check("to_instr", instr,            32'h0);
        check("to_fault", 32'(fetch_fault), 32'h1);
        commit = 1'b1;
        jump   = 1'b0;
        branch = 2'd0;
        @(negedge clk);
        commit = 1'b0;
        check("to_sticky", 32'(fetch_fault), 32'h1);
        check("to_next",   imem_addr,        32'h0000_0008);
`else
        check("wait_valid", 32'(instr_valid), 32'h0);
        check("wait_req",   32'(imem_req),    32'h1);
        check("wait_fault", 32'(fetch_fault), 32'h0);
        check("wait_instr", instr,            32'h1234_5678);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
